// File: rtl/accumulator_binary_saturating_if.sv
// Operation and result channels of the saturating accumulator.
// master drives operations and consumes results; slave is the accumulator.
interface accumulator_binary_saturating_if #(
  parameter int WORD_WIDTH = 16
);

  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_op;
  logic signed [WORD_WIDTH-1:0] in_data;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [WORD_WIDTH-1:0] accumulated_value;
  logic                         carry_out;
  logic                         saturated_max;
  logic                         saturated_min;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, accumulated_value, carry_out,
           saturated_max, saturated_min
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, accumulated_value, carry_out,
           saturated_max, saturated_min
  );

endinterface

// File: rtl/accumulator_binary_saturating.sv
// Signed accumulator with per-operation clipping to run-time limits.
// Optional saturation event counter: ACCUMULATOR_SATURATION_COUNT_EN.
module accumulator_binary_saturating #(
  parameter int WORD_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  accumulator_binary_saturating_if.slave bus,
  input  logic signed [WORD_WIDTH-1:0] max_limit,
  input  logic signed [WORD_WIDTH-1:0] min_limit,
  input  logic                         sticky_clear,
  output logic                         sticky_saturated
`ifdef ACCUMULATOR_SATURATION_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]       saturation_count
`endif
);

  localparam int EXT_WIDTH = WORD_WIDTH + 1;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  op_e                         op;
  logic                        accept;
  logic                        clip_event;

  logic signed [EXT_WIDTH-1:0] acc_ext;
  logic signed [EXT_WIDTH-1:0] data_ext;
  logic signed [EXT_WIDTH-1:0] max_ext;
  logic signed [EXT_WIDTH-1:0] min_ext;
  logic signed [EXT_WIDTH-1:0] raw_result;
  logic signed [EXT_WIDTH-1:0] clipped_result;

  logic                        next_carry;
  logic                        next_sat_max;
  logic                        next_sat_min;

  logic signed [WORD_WIDTH-1:0] acc_q;
  logic                         carry_q;
  logic                         sat_max_q;
  logic                         sat_min_q;
  logic                         out_valid_q;
  logic                         sticky_q;

  assign op     = op_e'(bus.in_op);
  assign accept = bus.in_valid && bus.in_ready;

  // A held result blocks new work unless the consumer takes it this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;

  assign acc_ext  = {acc_q[WORD_WIDTH-1], acc_q};
  assign data_ext = {bus.in_data[WORD_WIDTH-1], bus.in_data};
  assign max_ext  = {max_limit[WORD_WIDTH-1], max_limit};
  assign min_ext  = {min_limit[WORD_WIDTH-1], min_limit};

  always_comb begin
    raw_result = '0;
    unique case (op)
      OP_ADD:   raw_result = acc_ext + data_ext;
      OP_SUB:   raw_result = acc_ext - data_ext;
      OP_LOAD:  raw_result = data_ext;
      OP_CLEAR: raw_result = '0;
      default:  raw_result = '0;
    endcase
  end

  // The min check runs on the max-clipped value, so reversed limits land on min.
  always_comb begin
    clipped_result = raw_result;
    next_sat_max   = 1'b0;
    next_sat_min   = 1'b0;
    if (op != OP_CLEAR) begin
      if (clipped_result > max_ext) begin
        clipped_result = max_ext;
        next_sat_max   = 1'b1;
      end
      if (clipped_result < min_ext) begin
        clipped_result = min_ext;
        next_sat_min   = 1'b1;
        next_sat_max   = 1'b0;
      end
    end
  end

  assign next_carry = ((op == OP_ADD) || (op == OP_SUB)) ? raw_result[WORD_WIDTH] : 1'b0;
  assign clip_event = accept && (next_sat_max || next_sat_min);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      carry_q   <= 1'b0;
      sat_max_q <= 1'b0;
      sat_min_q <= 1'b0;
    end else if (accept) begin
      acc_q     <= clipped_result[WORD_WIDTH-1:0];
      carry_q   <= next_carry;
      sat_max_q <= next_sat_max;
      sat_min_q <= next_sat_min;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // A clip on the same edge as sticky_clear wins over the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (clip_event) begin
      sticky_q <= 1'b1;
    end else if (sticky_clear) begin
      sticky_q <= 1'b0;
    end
  end

`ifdef ACCUMULATOR_SATURATION_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clip_event) begin
      if (sticky_clear) begin
        count_q <= COUNT_WIDTH'(1);
      end else if (!(&count_q)) begin
        count_q <= count_q + 1'b1;
      end
    end else if (sticky_clear) begin
      count_q <= '0;
    end
  end

  assign saturation_count = count_q;
`else
  localparam int unused_count_width = COUNT_WIDTH;
`endif

  assign bus.out_valid         = out_valid_q;
  assign bus.accumulated_value = acc_q;
  assign bus.carry_out         = carry_q;
  assign bus.saturated_max     = sat_max_q;
  assign bus.saturated_min     = sat_min_q;
  assign sticky_saturated      = sticky_q;

endmodule

// File: tb/tb_accumulator_binary_saturating.sv
// Directed bench for accumulator_binary_saturating (WORD_WIDTH=8, COUNT_WIDTH=2).
// A vector table drives back-to-back operations; hand sequences cover handshake corners.
module tb_accumulator_binary_saturating;

  localparam int WORD_WIDTH  = 8;
  localparam int COUNT_WIDTH = 2;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct {
    string      name;
    logic [1:0] op;
    int         data;
    int         max;
    int         min;
    int         exp_value;
    int         exp_carry;
    int         exp_max;
    int         exp_min;
    int         exp_sticky;
    int         exp_count;
  } vec_t;

  logic clock;
  logic reset_n;
  logic signed [WORD_WIDTH-1:0] max_limit;
  logic signed [WORD_WIDTH-1:0] min_limit;
  logic sticky_clear;
  logic sticky_saturated;
`ifdef ACCUMULATOR_SATURATION_COUNT_EN
  logic [COUNT_WIDTH-1:0] saturation_count;
`endif

  int passed;
  int total;
  vec_t vecs[$];

  accumulator_binary_saturating_if #(.WORD_WIDTH(WORD_WIDTH)) bus ();

  accumulator_binary_saturating #(
    .WORD_WIDTH (WORD_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .bus             (bus.slave),
    .max_limit       (max_limit),
    .min_limit       (min_limit),
    .sticky_clear    (sticky_clear),
    .sticky_saturated(sticky_saturated)
`ifdef ACCUMULATOR_SATURATION_COUNT_EN
    ,
    .saturation_count(saturation_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic valid, input logic [1:0] op, input int data,
                                input int max, input int min);
    bus.in_valid = valid;
    bus.in_op    = op;
    bus.in_data  = 8'(data);
    max_limit    = 8'(max);
    min_limit    = 8'(min);
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input int data,
                         input int max, input int min, input int value, input int carry,
                         input int smax, input int smin, input int sticky, input int count);
    vec_t v;
    v.name = name; v.op = op; v.data = data; v.max = max; v.min = min;
    v.exp_value = value; v.exp_carry = carry; v.exp_max = smax; v.exp_min = smin;
    v.exp_sticky = sticky; v.exp_count = count;
    vecs.push_back(v);
  endtask

  task automatic check_count(input string name, input int expected);
`ifdef ACCUMULATOR_SATURATION_COUNT_EN
    check_output(name, int'(saturation_count), expected);
`else
    if (expected < 0) $display("[TB] unexpected count argument %0d in %s", expected, name);
`endif
  endtask

  initial begin
    passed = 0;
    total  = 0;

    add_vec("add50",     OP_ADD,    50,  100, -100,   50, 0, 0, 0, 0, 0);
    add_vec("add30",     OP_ADD,    30,  100, -100,   80, 0, 0, 0, 0, 0);
    add_vec("add40_clip",OP_ADD,    40,  100, -100,  100, 0, 1, 0, 1, 1);
    add_vec("sub127_a",  OP_SUB,   127,  100, -100,  -27, 1, 0, 0, 1, 1);
    add_vec("sub127_b",  OP_SUB,   127,  100, -100, -100, 1, 0, 1, 1, 2);
    add_vec("sub127_c",  OP_SUB,   127,  100, -100, -100, 1, 0, 1, 1, 3);
    add_vec("sub127_d",  OP_SUB,   127,  100, -100, -100, 1, 0, 1, 1, 3);
    add_vec("load_rev",  OP_LOAD,    0,  -10,   10,   10, 0, 0, 1, 1, 3);
    add_vec("clear",     OP_CLEAR,  99,  -10,   10,    0, 0, 0, 0, 1, 3);
    add_vec("load_hi",   OP_LOAD,  127,  100, -100,  100, 0, 1, 0, 1, 3);
    add_vec("load_lo",   OP_LOAD, -128,  100, -100, -100, 0, 0, 1, 1, 3);
    add_vec("add_neg",   OP_ADD,  -128,  100, -100, -100, 1, 0, 1, 1, 3);

    reset_n       = 1'b0;
    sticky_clear  = 1'b0;
    bus.out_ready = 1'b1;
    apply_stimulus(1'b0, OP_ADD, 0, 100, -100);

    repeat (2) @(negedge clock);
    check_output("reset_value",     int'(bus.accumulated_value), 0);
    check_output("reset_out_valid", int'(bus.out_valid), 0);
    check_output("reset_carry",     int'(bus.carry_out), 0);
    check_output("reset_sticky",    int'(sticky_saturated), 0);
    check_count("reset_count", 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_output("reset_in_ready", int'(bus.in_ready), 1);

    foreach (vecs[i]) begin
      @(negedge clock);
      apply_stimulus(1'b1, vecs[i].op, vecs[i].data, vecs[i].max, vecs[i].min);
      @(posedge clock); #1;
      check_output({vecs[i].name, "_value"},  int'(bus.accumulated_value), vecs[i].exp_value);
      check_output({vecs[i].name, "_carry"},  int'(bus.carry_out), vecs[i].exp_carry);
      check_output({vecs[i].name, "_smax"},   int'(bus.saturated_max), vecs[i].exp_max);
      check_output({vecs[i].name, "_smin"},   int'(bus.saturated_min), vecs[i].exp_min);
      check_output({vecs[i].name, "_sticky"}, int'(sticky_saturated), vecs[i].exp_sticky);
      check_output({vecs[i].name, "_valid"},  int'(bus.out_valid), 1);
      check_count({vecs[i].name, "_count"}, vecs[i].exp_count);
    end

    // Idle with out_ready high: result drains, value and flags hold.
    @(negedge clock);
    apply_stimulus(1'b0, OP_ADD, 0, 100, -100);
    @(posedge clock); #1;
    check_output("drain_valid", int'(bus.out_valid), 0);
    check_output("hold_value",  int'(bus.accumulated_value), -100);
    check_output("hold_smin",   int'(bus.saturated_min), 1);

    @(negedge clock);
    sticky_clear = 1'b1;
    @(posedge clock); #1;
    check_output("clear_sticky", int'(sticky_saturated), 0);
    check_count("clear_count", 0);

    // Clip on the same edge as sticky_clear: the set wins.
    @(negedge clock);
    apply_stimulus(1'b1, OP_ADD, -50, 100, -100);
    @(posedge clock); #1;
    check_output("setwins_sticky", int'(sticky_saturated), 1);
    check_count("setwins_count", 1);
    check_output("setwins_value",  int'(bus.accumulated_value), -100);

    // Backpressure: pending add 30 waits five cycles, then goes through.
    @(negedge clock);
    sticky_clear  = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, OP_ADD, 30, 100, -100);
    #1;
    check_output("bp_in_ready", int'(bus.in_ready), 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check_output("bp_value", int'(bus.accumulated_value), -100);
      check_output("bp_valid", int'(bus.out_valid), 1);
      check_output("bp_smin",  int'(bus.saturated_min), 1);
      check_output("bp_ready", int'(bus.in_ready), 0);
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    check_output("bp_release_value", int'(bus.accumulated_value), -70);
    check_output("bp_release_carry", int'(bus.carry_out), 1);
    check_output("bp_release_smin",  int'(bus.saturated_min), 0);
    check_output("bp_release_valid", int'(bus.out_valid), 1);

    // Reset while a result is held discards it.
    @(negedge clock);
    apply_stimulus(1'b0, OP_LOAD, 55, 100, -100);
    bus.out_ready = 1'b0;
    @(posedge clock); #1;
    check_output("hold_pre_reset", int'(bus.out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midreset_value",  int'(bus.accumulated_value), 0);
    check_output("midreset_valid",  int'(bus.out_valid), 0);
    check_output("midreset_sticky", int'(sticky_saturated), 0);
    check_output("midreset_ready",  int'(bus.in_ready), 1);
    check_count("midreset_count", 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_output("postreset_ready", int'(bus.in_ready), 1);
    check_output("postreset_valid", int'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
